tile_sched_ctrl: RTL and testbench
==================================

// Module: tile_sched_ctrl
// PURPOSE
//  Sequences an IMG_W x IMG_H image through tile window buffers as overlapping TILE_W x TILE_H tiles.
//  Tiles step by a stride of TILE-WIN_SIZE+1, so every output window is produced exactly once.
//  Issues tile-origin requests to the DMA and steers pixel beats into a buffer write port.
//  Starts each window sweep and counts its windows to detect completion.
//  Sits between the frame DMA and one or two tile window buffer instances.
// PARAMETERS
//  IMG_W    58  image width in pixels; (IMG_W-TILE_W) must be a multiple of SX=TILE_W-WIN_SIZE+1
//  IMG_H    58  image height in pixels; (IMG_H-TILE_H) must be a multiple of SY=TILE_H-WIN_SIZE+1
//  TILE_W   16  tile width in pixels
//  TILE_H   16  tile height in pixels
//  WIN_SIZE 3   window edge; sets the tile overlap and windows per tile NWIN=SX*SY
// PORTS
//  clk           in   1   clock
//  rst_n         in   1   asynchronous active-low reset
//  start         in   1   frame start pulse; accepted only when busy=0
//  abort         in   1   synchronous abort; returns the block to IDLE on the next cycle
//  busy          out  1   frame in progress
//  done          out  1   1-cycle pulse when the last tile's sweep completes
//  ld_req_valid  out  1   tile load request
//  ld_req_ready  in   1   DMA accepts the request
//  ld_org_x      out  $clog2(IMG_W)  tile origin column = tx*SX
//  ld_org_y      out  $clog2(IMG_H)  tile origin row = ty*SY
//  pix_valid     in   1   DMA pixel beat
//  buf_wr_valid  out  1   buffer write strobe (load_valid of the selected buffer)
//  buf_wr_sel    out  1   target buffer index
//  sw_start      out  1   1-cycle sweep start pulse
//  sw_sel        out  1   buffer being swept
//  win_valid     in   1   window-valid beat from the swept buffer
//  err           out  1   sticky protocol error; cleared on an accepted start
// BEHAVIOUR
//  Reset/abort: all outputs are 0; tile counters are 0; both buffers are empty.
//  - After an abort, the first request is re-issued from tile (0,0) on the next start.
//  Tiles run in raster order: tx=0..NTX-1, then ty. NTX=(IMG_W-TILE_W)/SX+1, NTY likewise.
//  Load FSM states: L_IDLE, L_REQ, L_FILL, L_WAIT.
//  - start (busy=0) -> L_REQ on the next cycle; busy=1 and ld_req_valid=1 that cycle.
//  - L_REQ: ld_req_valid, ld_org_x and ld_org_y are held stable until ld_req_ready; the transfer is valid&ready -> L_FILL.
//  - L_FILL: buf_wr_valid=pix_valid (combinational), buf_wr_sel=load buffer. Beat counter runs 0..TILE_W*TILE_H-1.
//  - Last beat: buffer marked full, tile index advances. Next state is L_REQ if a free buffer remains, L_WAIT if none, L_IDLE after the last tile.
//  - L_WAIT -> L_REQ in the cycle after a buffer is freed.
//  Sweep FSM states: S_IDLE, S_RUN.
//  - S_IDLE with the oldest tile's buffer full -> sw_start pulse and sw_sel=that buffer -> S_RUN.
//  - S_RUN counts win_valid beats. On beat NWIN the buffer is freed in that cycle -> S_IDLE.
//  - sw_start for the next tile can assert in the following cycle.
//  done pulses in the cycle the last tile's NWIN-th window is counted; busy falls in the same cycle.
//  Errors (err set, beat ignored): pix_valid outside L_FILL; win_valid outside S_RUN.
//  Simultaneous fill-complete and sweep-complete in one cycle: both take effect, with no lost state.
//  start while busy is ignored; it does not set err.
//  abort has priority over all other inputs, including an in-flight request (ld_req_valid drops).
// CONFIGURATION
//  TILE_PINGPONG_EN defined: two buffers; loads alternate sel 0,1,0,...
//  - The load of tile k+1 overlaps the sweep of tile k.
//  - Sweeps occur in load order.
//  TILE_PINGPONG_EN undefined: one buffer; buf_wr_sel=sw_sel=0.
//  - The request for tile k+1 is issued only after tile k's sweep frees the buffer.
// TESTING
//  1. Reset, then start with DMA always ready, pix_valid=1, and win_valid=1 in S_RUN.
//     -> 16 requests with origins (0,0),(14,0),(28,0),(42,0),(0,14),...,(42,42).
//     -> 256 writes per tile; done once; busy=0 after done; err=0.
//  2. Stall ld_req_ready low for 10 cycles.
//     -> ld_req_valid and the origin are stable throughout; no buf_wr_valid occurs.
//  3. TILE_PINGPONG_EN defined: tile 1 fill overlaps tile 0 sweep, with buf_wr_sel=1 and sw_sel=0.
//     -> No third request is issued while both buffers are full.
//  4. TILE_PINGPONG_EN undefined: tile 1 request occurs only after tile 0's 196th win_valid.
//  5. pix_valid pulse in L_IDLE, then win_valid in S_IDLE.
//     -> err=1 and no write occurs; err clears on the next start.
//  6. abort mid-fill of tile 5 -> all outputs are 0 next cycle.
//     -> Restart issues origin (0,0) and completes normally. Repeat with rst_n asserted mid-sweep.

Source files
------------

// File: rtl/tile_sched_ctrl.sv
// Tile scheduler: walks an image as overlapping tiles, feeds DMA requests and buffer writes,
// and sequences window sweeps. Define TILE_PINGPONG_EN for two alternating tile buffers.
module tile_sched_ctrl #(
    parameter int IMG_W    = 58,
    parameter int IMG_H    = 58,
    parameter int TILE_W   = 16,
    parameter int TILE_H   = 16,
    parameter int WIN_SIZE = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic                     ld_req_valid,
    input  logic                     ld_req_ready,
    output logic [$clog2(IMG_W)-1:0] ld_org_x,
    output logic [$clog2(IMG_H)-1:0] ld_org_y,
    input  logic                     pix_valid,
    output logic                     buf_wr_valid,
    output logic                     buf_wr_sel,
    output logic                     sw_start,
    output logic                     sw_sel,
    input  logic                     win_valid,
    output logic                     err
);

    localparam int SX   = TILE_W - WIN_SIZE + 1;
    localparam int SY   = TILE_H - WIN_SIZE + 1;
    localparam int NTX  = (IMG_W - TILE_W) / SX + 1;
    localparam int NTY  = (IMG_H - TILE_H) / SY + 1;
    localparam int NT   = NTX * NTY;
    localparam int NWIN = SX * SY;
    localparam int NPIX = TILE_W * TILE_H;

    localparam int XW  = $clog2(IMG_W);
    localparam int YW  = $clog2(IMG_H);
    localparam int BW  = $clog2(NPIX);
    localparam int WW  = $clog2(NWIN);
    localparam int TXW = $clog2(NTX + 1);
    localparam int TYW = $clog2(NTY + 1);
    localparam int TW  = $clog2(NT + 1);

    localparam logic [BW-1:0]  BEAT_LAST = BW'(NPIX - 1);
    localparam logic [WW-1:0]  WIN_LAST  = WW'(NWIN - 1);
    localparam logic [TXW-1:0] TX_LAST   = TXW'(NTX - 1);
    localparam logic [TYW-1:0] TY_LAST   = TYW'(NTY - 1);
    localparam logic [TW-1:0]  T_LAST    = TW'(NT - 1);

`ifdef TILE_PINGPONG_EN
    localparam logic PINGPONG = 1'b1;
`else
    localparam logic PINGPONG = 1'b0;
`endif

    localparam logic [1:0] L_IDLE = 2'd0;
    localparam logic [1:0] L_REQ  = 2'd1;
    localparam logic [1:0] L_FILL = 2'd2;
    localparam logic [1:0] L_WAIT = 2'd3;
    localparam logic       S_IDLE = 1'b0;
    localparam logic       S_RUN  = 1'b1;

    logic [1:0]     ld_state_q, ld_state_d;
    logic           sw_state_q, sw_state_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic [1:0]     full_q, full_d;
    logic           load_sel_q, load_sel_d;
    logic           sw_sel_q, sw_sel_d;
    logic [BW-1:0]  beat_q, beat_d;
    logic [WW-1:0]  win_q, win_d;
    logic [TXW-1:0] tx_q, tx_d;
    logic [TYW-1:0] ty_q, ty_d;
    logic [XW-1:0]  org_x_q, org_x_d;
    logic [YW-1:0]  org_y_q, org_y_d;
    logic [TW-1:0]  sw_tile_q, sw_tile_d;

    logic start_acc, sw_kick, sw_last, next_sel, fill_free, wait_free;

    assign start_acc = start && !busy_q;
    assign sw_kick   = (sw_state_q == S_IDLE) && full_q[sw_sel_q];
    assign sw_last   = (sw_state_q == S_RUN) && win_valid && (win_q == WIN_LAST);
    assign next_sel  = PINGPONG ? ~load_sel_q : 1'b0;

    // A buffer freed by a sweep finishing this cycle counts as free right away.
    assign fill_free = PINGPONG &&
                       (!full_q[next_sel] || (sw_last && (sw_sel_q == next_sel)));
    assign wait_free = !full_q[load_sel_q] || (sw_last && (sw_sel_q == load_sel_q));

    always_comb begin
        ld_state_d = ld_state_q;
        sw_state_d = sw_state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q | (pix_valid && (ld_state_q != L_FILL))
                           | (win_valid && (sw_state_q != S_RUN));
        full_d     = full_q;
        load_sel_d = load_sel_q;
        sw_sel_d   = sw_sel_q;
        beat_d     = beat_q;
        win_d      = win_q;
        tx_d       = tx_q;
        ty_d       = ty_q;
        org_x_d    = org_x_q;
        org_y_d    = org_y_q;
        sw_tile_d  = sw_tile_q;

        // Clear before set: a fill and a sweep may complete in the same cycle.
        if (sw_last) full_d[sw_sel_q] = 1'b0;
        if (ld_state_q == L_FILL && pix_valid && beat_q == BEAT_LAST) full_d[load_sel_q] = 1'b1;

        case (ld_state_q)
            L_IDLE: begin
                if (start_acc) begin
                    ld_state_d = L_REQ;
                    busy_d     = 1'b1;
                    err_d      = 1'b0;
                end
            end
            L_REQ: begin
                if (ld_req_ready) begin
                    ld_state_d = L_FILL;
                    beat_d     = '0;
                end
            end
            L_FILL: begin
                if (pix_valid) begin
                    beat_d = beat_q + BW'(1);
                    if (beat_q == BEAT_LAST) begin
                        beat_d     = '0;
                        load_sel_d = next_sel;
                        if (tx_q == TX_LAST && ty_q == TY_LAST) begin
                            tx_d       = '0;
                            ty_d       = '0;
                            org_x_d    = '0;
                            org_y_d    = '0;
                            ld_state_d = L_IDLE;
                        end else begin
                            if (tx_q == TX_LAST) begin
                                tx_d    = '0;
                                org_x_d = '0;
                                ty_d    = ty_q + TYW'(1);
                                org_y_d = org_y_q + YW'(SY);
                            end else begin
                                tx_d    = tx_q + TXW'(1);
                                org_x_d = org_x_q + XW'(SX);
                            end
                            ld_state_d = fill_free ? L_REQ : L_WAIT;
                        end
                    end
                end
            end
            L_WAIT: begin
                if (wait_free) ld_state_d = L_REQ;
            end
            default: ld_state_d = L_IDLE;
        endcase

        if (sw_state_q == S_IDLE) begin
            if (sw_kick) begin
                sw_state_d = S_RUN;
                win_d      = '0;
            end
        end else if (win_valid) begin
            win_d = win_q + WW'(1);
            if (win_q == WIN_LAST) begin
                win_d      = '0;
                sw_state_d = S_IDLE;
                sw_sel_d   = PINGPONG ? ~sw_sel_q : 1'b0;
                if (sw_tile_q == T_LAST) begin
                    sw_tile_d = '0;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                end else begin
                    sw_tile_d = sw_tile_q + TW'(1);
                end
            end
        end

        if (abort) begin
            ld_state_d = L_IDLE;
            sw_state_d = S_IDLE;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            err_d      = 1'b0;
            full_d     = '0;
            load_sel_d = 1'b0;
            sw_sel_d   = 1'b0;
            beat_d     = '0;
            win_d      = '0;
            tx_d       = '0;
            ty_d       = '0;
            org_x_d    = '0;
            org_y_d    = '0;
            sw_tile_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_state_q <= L_IDLE;
            sw_state_q <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            full_q     <= '0;
            load_sel_q <= 1'b0;
            sw_sel_q   <= 1'b0;
            beat_q     <= '0;
            win_q      <= '0;
            tx_q       <= '0;
            ty_q       <= '0;
            org_x_q    <= '0;
            org_y_q    <= '0;
            sw_tile_q  <= '0;
        end else begin
            ld_state_q <= ld_state_d;
            sw_state_q <= sw_state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            full_q     <= full_d;
            load_sel_q <= load_sel_d;
            sw_sel_q   <= sw_sel_d;
            beat_q     <= beat_d;
            win_q      <= win_d;
            tx_q       <= tx_d;
            ty_q       <= ty_d;
            org_x_q    <= org_x_d;
            org_y_q    <= org_y_d;
            sw_tile_q  <= sw_tile_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign ld_req_valid = (ld_state_q == L_REQ);
    assign ld_org_x     = org_x_q;
    assign ld_org_y     = org_y_q;
    assign buf_wr_valid = (ld_state_q == L_FILL) && pix_valid;
    assign buf_wr_sel   = load_sel_q;
    assign sw_start     = sw_kick;
    assign sw_sel       = sw_sel_q;

endmodule

// File: tb/tb_tile_sched_ctrl.sv
// Bench for tile_sched_ctrl: randomized DMA/sweep handshakes checked against a transaction-level
// model of tile order, buffer occupancy and protocol errors.
module tb_tile_sched_ctrl;

    localparam int IMG_W = 58, IMG_H = 58, TILE_W = 16, TILE_H = 16, WIN_SIZE = 3;
    localparam int SX   = TILE_W - WIN_SIZE + 1;
    localparam int SY   = TILE_H - WIN_SIZE + 1;
    localparam int NTX  = (IMG_W - TILE_W) / SX + 1;
    localparam int NTY  = (IMG_H - TILE_H) / SY + 1;
    localparam int NT   = NTX * NTY;
    localparam int NWIN = SX * SY;
    localparam int NPIX = TILE_W * TILE_H;
`ifdef TILE_PINGPONG_EN
    localparam int NBUF = 2;
`else
    localparam int NBUF = 1;
`endif

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       start = 1'b0, abort = 1'b0, ld_req_ready = 1'b0;
    logic       pix_valid = 1'b0, win_valid = 1'b0;
    logic       busy, done, ld_req_valid, buf_wr_valid, buf_wr_sel, sw_start, sw_sel, err;
    logic [5:0] ld_org_x, ld_org_y;

    always #5 clk = ~clk;

    tile_sched_ctrl #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .TILE_W(TILE_W), .TILE_H(TILE_H), .WIN_SIZE(WIN_SIZE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy), .done(done),
        .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready), .ld_org_x(ld_org_x),
        .ld_org_y(ld_org_y), .pix_valid(pix_valid), .buf_wr_valid(buf_wr_valid),
        .buf_wr_sel(buf_wr_sel), .sw_start(sw_start), .sw_sel(sw_sel),
        .win_valid(win_valid), .err(err)
    );

    int checks = 0, errors = 0;
    int busy_m, done_m, err_m, fill_m, sweep_m, pend_m;
    int acc_m, wr_cnt, loaded_m, started_m, win_cnt, swdone_m, done_cnt;
    int rdy_pct = 100, pix_pct = 100, win_pct = 100;
    bit overlap_seen = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        busy_m = 0; done_m = 0; err_m = 0; fill_m = 0; sweep_m = 0; pend_m = 0;
        acc_m = 0; wr_cnt = 0; loaded_m = 0; started_m = 0; win_cnt = 0; swdone_m = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {busy, done, ld_req_valid, ld_org_x, ld_org_y, buf_wr_valid, buf_wr_sel,
                  sw_start, sw_sel, err}, 0);
    endtask

    // Compare this cycle's outputs with the model, then advance the model by one cycle.
    task automatic sample();
        int sw_exp;
        chk("busy", busy, busy_m);
        chk("done", done, done_m);
        chk("err", err, err_m);
        chk("wr_valid", buf_wr_valid, pix_valid && fill_m != 0);
        sw_exp = (sweep_m == 0 && loaded_m > started_m) ? 1 : 0;
        chk("sw_start", sw_start, sw_exp);
        if (done) done_cnt++;
        if (ld_req_valid) begin
            chk("req_capacity", (acc_m - swdone_m < NBUF) && (acc_m < NT), 1);
            chk("org_x", ld_org_x, (acc_m % NTX) * SX);
            chk("org_y", ld_org_y, (acc_m / NTX) * SY);
        end
        if (pend_m != 0) chk("req_hold", ld_req_valid, 1);
        if (buf_wr_valid) chk("wr_sel", buf_wr_sel, (acc_m - 1) % NBUF);
        if (sw_start) chk("sw_sel", sw_sel, started_m % NBUF);
        if (buf_wr_valid && buf_wr_sel && sweep_m != 0 && !sw_sel) overlap_seen = 1'b1;

        done_m = 0;
        if (start && busy_m == 0) begin
            busy_m = 1;
            err_m  = 0;
        end else if ((pix_valid && fill_m == 0) || (win_valid && sweep_m == 0)) begin
            err_m = 1;
        end
        if (pix_valid && fill_m != 0) begin
            wr_cnt++;
            if (wr_cnt == NPIX) begin
                fill_m = 0;
                loaded_m++;
            end
        end
        pend_m = (ld_req_valid && !ld_req_ready) ? 1 : 0;
        if (ld_req_valid && ld_req_ready) begin
            acc_m++;
            fill_m = 1;
            wr_cnt = 0;
        end
        if (sw_exp != 0) begin
            started_m++;
            sweep_m = 1;
            win_cnt = 0;
        end else if (sweep_m != 0 && win_valid) begin
            win_cnt++;
            if (win_cnt == NWIN) begin
                sweep_m = 0;
                swdone_m++;
                if (swdone_m == NT) begin
                    done_m = 1; busy_m = 0;
                    acc_m = 0; loaded_m = 0; started_m = 0; swdone_m = 0;
                end
            end
        end
    endtask

    task automatic tick(input bit st = 0, input bit ab = 0, input bit ep = 0, input bit ew = 0);
        @(posedge clk); #1;
        start        = st;
        abort        = ab;
        ld_req_ready = ($urandom_range(99) < rdy_pct);
        pix_valid    = ep || (fill_m != 0 && $urandom_range(99) < pix_pct);
        win_valid    = ew || (sweep_m != 0 && $urandom_range(99) < win_pct);
        @(negedge clk);
        sample();
        if (ab) model_reset();
    endtask

    task automatic run_frame(input string name, input int budget);
        int n = 0;
        while ((busy_m != 0 || done_m != 0) && n < budget) begin
            tick();
            n++;
        end
        chk({name, "_timeout"}, n < budget, 1);
        chk({name, "_done_cnt"}, done_cnt, 1);
        chk({name, "_busy_end"}, busy, 0);
        chk({name, "_err_end"}, err, 0);
    endtask

    initial begin
        int n;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk_zero("reset_state");

        // Full-throughput frame.
        done_cnt = 0;
        tick(.st(1));
        run_frame("full_rate", 20000);
`ifdef TILE_PINGPONG_EN
        chk("fill_overlaps_sweep", overlap_seen, 1);
`endif

        // Stray beats while idle, then a start clears err.
        tick(.ep(1));
        tick(.ew(1));
        chk("err_set", err, 1);
        rdy_pct = 0;
        done_cnt = 0;
        tick(.st(1));
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 0) chk("err_clear", err, 0);
            chk("stall_valid", ld_req_valid, 1);
            chk("stall_org", {ld_org_x, ld_org_y}, 0);
            chk("stall_no_wr", buf_wr_valid, 0);
        end
        rdy_pct = 60; pix_pct = 70; win_pct = 60;
        run_frame("random_rate", 40000);

        // Abort in the middle of tile 5's fill, then restart from the top.
        rdy_pct = 100; pix_pct = 100; win_pct = 100;
        done_cnt = 0;
        tick(.st(1));
        n = 0;
        while (!(acc_m == 6 && wr_cnt >= 20) && n < 20000) begin
            tick();
            n++;
        end
        chk("reach_tile5", n < 20000, 1);
        tick(.ab(1));
        tick();
        chk_zero("after_abort");
        done_cnt = 0;
        tick(.st(1));
        tick();
        chk("restart_req", {ld_req_valid, ld_org_x, ld_org_y}, 32'h1000);
        run_frame("after_abort", 20000);

        // Asynchronous reset in the middle of a sweep.
        done_cnt = 0;
        tick(.st(1));
        n = 0;
        while (!(swdone_m == 2 && win_cnt >= 50) && n < 20000) begin
            tick();
            n++;
        end
        chk("reach_sweep", n < 20000, 1);
        @(posedge clk); #1;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        ld_req_ready = 1'b0; pix_valid = 1'b0; win_valid = 1'b0;
        @(negedge clk);
        chk_zero("after_reset");
        model_reset();
        @(posedge clk); #1 rst_n = 1'b1;
        done_cnt = 0;
        tick(.st(1));
        run_frame("after_reset", 20000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
